// File: rtl/zbus_fifo.sv
// Elastic zbus channel buffer: DEPTH-entry show-ahead queue between s_* and m_*,
// with occupancy output and a saturating counter of input-side stability violations.
module zbus_fifo #(
  parameter int WA    = 32,
  parameter int WD    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_vld,
  input  logic          s_aen,
  input  logic          s_den,
  input  logic [WA-1:0] s_adr,
  input  logic [WD-1:0] s_dat,
  output logic          s_rdy,
  output logic          m_vld,
  output logic          m_aen,
  output logic          m_den,
  output logic [WA-1:0] m_adr,
  output logic [WD-1:0] m_dat,
  input  logic          m_rdy,
  output logic [CW-1:0] cnt,
  output logic [15:0]   err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic          aen;
    logic          den;
    logic [WA-1:0] adr;
    logic [WD-1:0] dat;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [CW-1:0] r_wp;
  logic [CW-1:0] r_rp;
  logic          r_pend;
  entry_t        r_hold;
  logic [15:0]   r_err;

  entry_t        w_in;
  entry_t        w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_viol;

  assign w_in    = {s_aen, s_den, s_adr, s_dat};
  assign w_head  = r_mem[r_rp[AW-1:0]];
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[CW-1] != r_rp[CW-1]);

  // Ready comes from registered pointers only; the reset term keeps producers off
  // the link while the queue is being cleared.
  assign s_rdy  = rst && !w_full;
  assign m_vld  = !w_empty;
  assign w_push = s_vld && s_rdy;
  assign w_pop  = m_vld && m_rdy;

  // A held request must keep s_vld high and its payload frozen until accepted.
  assign w_viol = r_pend && (!s_vld || (w_in != r_hold));

  // NOTE: all state, including every array entry, is cleared so the head payload
  // reads as zero after reset rather than showing stale data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_pend <= 1'b0;
      r_hold <= '0;
      r_err  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values and push/pop on the same edge cannot race each other.
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= w_in;
        r_wp                <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      r_pend <= s_vld && !s_rdy;
      r_hold <= w_in;
      if (w_viol && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign m_aen = w_head.aen;
  assign m_den = w_head.den;
  assign m_adr = w_head.adr;
  assign m_dat = w_head.dat;
  assign cnt   = r_wp - r_rp;
  assign err   = r_err;

endmodule

// File: tb/tb_zbus_fifo.sv
// Directed bench for zbus_fifo: vector table for reset/fill/drain, hand sequences
// for streaming wrap, checker counting and saturation, and mid-stream reset.
module tb_zbus_fifo;

  localparam int WA = 32;
  localparam int WD = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_vld, s_aen, s_den;
  logic [WA-1:0] s_adr;
  logic [WD-1:0] s_dat;
  logic          s_rdy;
  logic          m_vld, m_aen, m_den;
  logic [WA-1:0] m_adr;
  logic [WD-1:0] m_dat;
  logic          m_rdy;
  logic [CW-1:0] cnt;
  logic [15:0]   err;

  int n_checks = 0;
  int n_errors = 0;

  zbus_fifo #(.WA(WA), .WD(WD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_aen(s_aen), .s_den(s_den), .s_adr(s_adr), .s_dat(s_dat),
    .s_rdy(s_rdy),
    .m_vld(m_vld), .m_aen(m_aen), .m_den(m_den), .m_adr(m_adr), .m_dat(m_dat),
    .m_rdy(m_rdy),
    .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld, aen, den;
    logic [31:0] adr;
    logic        mrdy;
    logic        e_srdy, e_mvld, e_aen, e_den;
    logic [31:0] e_adr;
    logic [2:0]  e_cnt;
    logic [15:0] e_err;
    logic        chk_pay;
  } vec_t;

  // Stored data convention for table entries: dat = adr + 0x100 (zero for a zeroed slot).
  function automatic logic [31:0] dat_of(input logic [31:0] adr);
    return (adr == 32'd0) ? 32'd0 : adr + 32'h100;
  endfunction

  function automatic vec_t mk(input logic r, v, a, d, input logic [31:0] adr, input logic mr,
                              input logic esr, emv, ea, ed, input logic [31:0] eadr,
                              input logic [2:0] ec, input logic [15:0] ee, input logic cp);
    vec_t t;
    t = '{rst: r, vld: v, aen: a, den: d, adr: adr, mrdy: mr,
          e_srdy: esr, e_mvld: emv, e_aen: ea, e_den: ed, e_adr: eadr,
          e_cnt: ec, e_err: ee, chk_pay: cp};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, a, d, input logic [31:0] adr, dat, input logic mr);
    rst = r; s_vld = v; s_aen = a; s_den = d; s_adr = adr; s_dat = dat; m_rdy = mr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    //              rst vld aen den adr    mrdy  srdy mvld aen den eadr   cnt err chk
    vecs[0]  = mk(0, 1, 1, 0, 32'h10, 0,   0, 0, 0, 0, 32'h00, 0, 0, 1);
    vecs[1]  = mk(0, 1, 1, 0, 32'h10, 0,   0, 0, 0, 0, 32'h00, 0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 0, 32'h00, 0,   1, 0, 0, 0, 32'h00, 0, 0, 1);
    vecs[3]  = mk(1, 1, 1, 0, 32'h10, 0,   1, 1, 1, 0, 32'h10, 1, 0, 1);
    vecs[4]  = mk(1, 1, 1, 1, 32'h11, 0,   1, 1, 1, 0, 32'h10, 2, 0, 1);
    vecs[5]  = mk(1, 1, 0, 0, 32'h12, 0,   1, 1, 1, 0, 32'h10, 3, 0, 1);
    vecs[6]  = mk(1, 1, 0, 1, 32'h13, 0,   0, 1, 1, 0, 32'h10, 4, 0, 1);
    vecs[7]  = mk(1, 1, 1, 1, 32'h14, 0,   0, 1, 1, 0, 32'h10, 4, 0, 1);
    vecs[8]  = mk(1, 1, 1, 1, 32'h14, 0,   0, 1, 1, 0, 32'h10, 4, 0, 1);
    vecs[9]  = mk(1, 1, 1, 1, 32'h14, 1,   1, 1, 1, 1, 32'h11, 3, 0, 1);
    vecs[10] = mk(1, 1, 1, 1, 32'h14, 0,   0, 1, 1, 1, 32'h11, 4, 0, 1);
    vecs[11] = mk(1, 0, 0, 0, 32'h00, 1,   1, 1, 0, 0, 32'h12, 3, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 32'h00, 1,   1, 1, 0, 1, 32'h13, 2, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 32'h00, 1,   1, 1, 1, 1, 32'h14, 1, 0, 1);
    vecs[14] = mk(1, 0, 0, 0, 32'h00, 1,   1, 0, 0, 0, 32'h00, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].aen, vecs[i].den,
            vecs[i].adr, dat_of(vecs[i].adr), vecs[i].mrdy);
      step();
      check($sformatf("v%0d_s_rdy", i), 64'(s_rdy), 64'(vecs[i].e_srdy));
      check($sformatf("v%0d_m_vld", i), 64'(m_vld), 64'(vecs[i].e_mvld));
      check($sformatf("v%0d_cnt", i),   64'(cnt),   64'(vecs[i].e_cnt));
      check($sformatf("v%0d_err", i),   64'(err),   64'(vecs[i].e_err));
      if (vecs[i].chk_pay) begin
        check($sformatf("v%0d_m_aen", i), 64'(m_aen), 64'(vecs[i].e_aen));
        check($sformatf("v%0d_m_den", i), 64'(m_den), 64'(vecs[i].e_den));
        check($sformatf("v%0d_m_adr", i), 64'(m_adr), 64'(vecs[i].e_adr));
        check($sformatf("v%0d_m_dat", i), 64'(m_dat), 64'(dat_of(vecs[i].e_adr)));
      end
    end

    // Streaming across several pointer wraps: one in, one out per cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(i), 32'(i), 1'b1);
      step();
      check($sformatf("stream%0d_m_dat", i), 64'(m_dat), 64'(i));
      check($sformatf("stream%0d_m_adr", i), 64'(m_adr), 64'(32'h200 + 32'(i)));
      check($sformatf("stream%0d_cnt", i), 64'(cnt), 64'd1);
      check($sformatf("stream%0d_s_rdy", i), 64'(s_rdy), 64'd1);
    end
    check("stream_err", 64'(err), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    check("stream_drained_cnt", 64'(cnt), 64'd0);
    check("stream_drained_m_vld", 64'(m_vld), 64'd0);

    // Checker: fill, then hold a request against the full queue.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h30 + 32'(k), 32'h300 + 32'(k), 1'b0);
      step();
    end
    check("chk_full_cnt", 64'(cnt), 64'd4);
    check("chk_full_s_rdy", 64'(s_rdy), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h50, 1'b0);
    step();
    step();
    check("chk_stable_err", 64'(err), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h41, 32'h50, 1'b0);
    step();
    check("chk_adr_change_err", 64'(err), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h41, 32'h50, 1'b0);
    step();
    check("chk_vld_drop_err", 64'(err), 64'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h41, 32'h50, 1'b0);
    step();
    check("chk_restart_err", 64'(err), 64'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h42, 32'h51, 1'b0);
    step();
    check("chk_two_fields_err", 64'(err), 64'd3);
    step();
    check("chk_hold_again_err", 64'(err), 64'd3);
    check("chk_head_untouched", 64'(m_adr), 64'h30);
    check("chk_cnt_untouched", 64'(cnt), 64'd4);

    // Drive err up to saturation with one violation per cycle.
    for (int k = 0; k < 65531; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000 + 32'(k), 32'h51, 1'b0);
      step();
    end
    check("sat_fffe", 64'(err), 64'hFFFE);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h51, 1'b0);
    step();
    check("sat_ffff", 64'(err), 64'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h51, 1'b0);
    step();
    check("sat_hold", 64'(err), 64'hFFFF);

    // Mid-stream reset from cnt=3.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    check("pre_reset_cnt", 64'(cnt), 64'd3);
    check("pre_reset_err", 64'(err), 64'hFFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    check("mid_reset_cnt", 64'(cnt), 64'd0);
    check("mid_reset_m_vld", 64'(m_vld), 64'd0);
    check("mid_reset_err", 64'(err), 64'd0);
    check("mid_reset_s_rdy", 64'(s_rdy), 64'd0);
    check("mid_reset_m_adr", 64'(m_adr), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 32'hA5, 1'b0);
    step();
    check("post_reset_cnt", 64'(cnt), 64'd1);
    check("post_reset_m_vld", 64'(m_vld), 64'd1);
    check("post_reset_m_dat", 64'(m_dat), 64'hA5);
    check("post_reset_m_den", 64'(m_den), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step();
    check("post_reset_drain_cnt", 64'(cnt), 64'd0);
    check("post_reset_drain_m_vld", 64'(m_vld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
